mod_dec_shifter: RTL and testbench

Inverse ShiftRows stage for the AES-256 decryption datapath. It is the decoder-side counterpart of the encryption shifter. It accepts one 4-byte state row per write and rotates it right by the current row index (0..3), undoing the encryption-side left rotation. An internal row counter tracks which row of the 4x4 state is being processed. Output is registered, with a one-cycle `done` pulse per row, ahead of InvSubBytes.

---
 rtl/mod_dec_shifter.sv | 62 ++++++
 tb/tb_mod_dec_shifter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mod_dec_shifter.sv
// Inverse ShiftRows stage for the AES-256 decryption datapath.
// Rotates each accepted 4-byte row right by its row index, with a registered output and done pulse.
module mod_dec_shifter #(
   parameter int unsigned N = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                wr_en,
   input  logic                sof,
   input  logic [N-1:0][7:0]   inp,
   output logic [N-1:0][7:0]   outp,
   output logic                done,
   output logic [1:0]          row_idx,
   output logic                last
);

   localparam int unsigned ROW_W = 2;

   generate
      if (N != 4) begin : g_bad_n
         $error("mod_dec_shifter supports only N = 4");
      end
   endgenerate

   logic [ROW_W-1:0]  r_rcnt;
   logic [ROW_W-1:0]  w_row;
   logic [N-1:0][7:0] w_rot;

   // sof restarts the state at row 0 for the write it accompanies
   assign w_row = sof ? ROW_W'(0) : r_rcnt;

   // Right rotation by w_row: out[c] takes in[(c - row) mod 4]
   always_comb begin
      w_rot = '0;
      for (int c = 0; c < 4; c++) begin
         w_rot[c] = inp[ROW_W'(ROW_W'(c) - w_row)];
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_rcnt  <= '0;
         outp    <= '0;
         done    <= 1'b0;
         row_idx <= '0;
         last    <= 1'b0;
      end else if (wr_en) begin
         outp    <= w_rot;
         row_idx <= w_row;
         done    <= 1'b1;
         last    <= (w_row == ROW_W'(3));
         r_rcnt  <= ROW_W'(w_row + ROW_W'(1));
      end else begin
         done    <= 1'b0;
         last    <= 1'b0;
         if (sof) begin
            r_rcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mod_dec_shifter.sv
// Self-checking bench for mod_dec_shifter: directed scenarios plus random traffic
// compared against a byte-array reference model of inverse ShiftRows.
module tb_mod_dec_shifter;

   logic             clk;
   logic             resetn;
   logic             wr_en;
   logic             sof;
   logic [3:0][7:0]  inp;
   logic [3:0][7:0]  outp;
   logic             done;
   logic [1:0]       row_idx;
   logic             last;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   int          m_row = 0;
   logic [31:0] m_out = 32'h0;
   int          m_idx = 0;
   logic        m_done = 1'b0;
   logic        m_last = 1'b0;

   mod_dec_shifter #(.N(4)) u_dut (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (wr_en),
      .sof     (sof),
      .inp     (inp),
      .outp    (outp),
      .done    (done),
      .row_idx (row_idx),
      .last    (last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".outp"},    32'(outp),    m_out);
      check({tag, ".done"},    32'(done),    32'(m_done));
      check({tag, ".row_idx"}, 32'(row_idx), 32'(m_idx));
      check({tag, ".last"},    32'(last),    32'(m_last));
   endtask

   // One clock: drive at negedge, update model, compare just after the rising edge
   task automatic step(input string tag, input logic we, input logic s, input logic [31:0] data);
      logic [7:0] b_in [4];
      logic [7:0] b_out[4];
      int r;
      @(negedge clk);
      wr_en = we;
      sof   = s;
      inp   = data;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) b_in[i] = data[8*i +: 8];
      if (we) begin
         r = s ? 0 : m_row;
         for (int c = 0; c < 4; c++) b_out[c] = b_in[(c - r + 4) % 4];
         m_out  = {b_out[3], b_out[2], b_out[1], b_out[0]};
         m_idx  = r;
         m_done = 1'b1;
         m_last = (r == 3);
         m_row  = (r + 1) % 4;
      end else begin
         m_done = 1'b0;
         m_last = 1'b0;
         if (s) m_row = 0;
      end
      check_all(tag);
   endtask

   task automatic model_reset();
      m_row = 0; m_out = 32'h0; m_idx = 0; m_done = 1'b0; m_last = 1'b0;
   endtask

   initial begin
      resetn = 1'b1;
      wr_en  = 1'b0;
      sof    = 1'b0;
      inp    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      model_reset();
      check_all("reset");

      // full state: rows 0..3 of {00,01,02,03}
      for (int k = 0; k < 4; k++) step("full", 1'b1, 1'b0, 32'h03020100);
      check("full.last_row3", 32'(last), 32'd1);
      check("full.out_row3", 32'(outp), 32'h00030201);

      // round trip with encryption-side rotated rows
      step("rt0", 1'b1, 1'b0, 32'h03020100);
      check("rt0.value", 32'(outp), 32'h03020100);
      step("rt1", 1'b1, 1'b0, 32'h00030201);
      check("rt1.value", 32'(outp), 32'h03020100);
      step("rt2", 1'b1, 1'b0, 32'h01000302);
      check("rt2.value", 32'(outp), 32'h03020100);
      step("rt3", 1'b1, 1'b0, 32'h02010003);
      check("rt3.value", 32'(outp), 32'h03020100);

      // gap: write, two idle cycles, write on row 1
      step("gap_w0", 1'b1, 1'b0, 32'hA1B2C3D4);
      step("gap_i0", 1'b0, 1'b0, 32'h11111111);
      step("gap_i1", 1'b0, 1'b0, 32'h22222222);
      step("gap_w1", 1'b1, 1'b0, 32'h44332211);
      check("gap.row1", 32'(row_idx), 32'd1);

      // wrap: five writes starting from a sof write
      step("wrap0", 1'b1, 1'b1, 32'h0F0E0D0C);
      for (int k = 1; k < 5; k++) step("wrap", 1'b1, 1'b0, 32'h0F0E0D0C + 32'(k));
      check("wrap.row0", 32'(row_idx), 32'd0);

      // sof resync mid-state
      step("sync_a", 1'b1, 1'b0, 32'h55667788);
      step("sync_b", 1'b1, 1'b0, 32'h99AABBCC);
      step("sync_s", 1'b1, 1'b1, 32'h03020100);
      check("sync.value", 32'(outp), 32'h03020100);
      step("sync_n", 1'b1, 1'b0, 32'hDEADBEEF);
      check("sync.next_row1", 32'(row_idx), 32'd1);

      // sof without a write clears the counter only
      step("sofidle", 1'b0, 1'b1, 32'h12345678);
      step("sofidle_w", 1'b1, 1'b0, 32'h87654321);
      check("sofidle.row0", 32'(row_idx), 32'd0);

      // asynchronous reset mid-cycle while outp is nonzero
      step("pre_rst", 1'b1, 1'b0, 32'hCAFEF00D);
      #2;
      resetn = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      wr_en  = 1'b0;
      sof    = 1'b0;
      resetn = 1'b0;
      step("post_rst", 1'b1, 1'b0, 32'h0BADCAFE);
      check("post_rst.row0", 32'(row_idx), 32'd0);

      // random traffic
      for (int k = 0; k < 300; k++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
